param_mem_controller: RTL and testbench

PARAM_MEM_CONTROLLER -- requirements
Module: param_mem_controller

---
 rtl/param_mem_controller.sv | 99 +++++++++
 tb/tb_param_mem_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/param_mem_controller.sv
// Command-queued single-port memory controller: writes and reads are buffered in a
// circular FIFO and executed in order by a three-state IDLE/EXEC/RESP sequencer.
module param_mem_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_mem,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_we,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr,
    input  logic [DATA_WIDTH-1:0]         cmd_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                  state;
    logic [EW-1:0]           fifo [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic                    ex_we;
    logic [ADDR_WIDTH-1:0]   ex_addr;
    logic [DATA_WIDTH-1:0]   ex_wdata;
    logic [DATA_WIDTH-1:0]   mem [1 << ADDR_WIDTH];
    logic                    push, pop;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == IDLE) && !empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
        end else if (push) begin
            fifo[wr_ptr] <= {cmd_we, cmd_addr, cmd_wdata};
            wr_ptr       <= wr_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset)
            count <= '0;
        else if (push && !pop)
            count <= count + CW'(1);
        else if (pop && !push)
            count <= count - CW'(1);
    end

    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            ex_we     <= 1'b0;
            ex_addr   <= '0;
            ex_wdata  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    {ex_we, ex_addr, ex_wdata} <= fifo[rd_ptr];
                    rd_ptr <= rd_ptr + PW'(1);
                    state  <= EXEC;
                end
                EXEC: if (ex_we) begin
                    state <= IDLE;
                end else begin
                    rsp_data  <= mem[ex_addr];
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage survives reset by design, so this array has no reset term.
    always_ff @(posedge clk_mem) begin
        if (state == EXEC && ex_we) mem[ex_addr] <= ex_wdata;
    end
endmodule

// File: tb/tb_param_mem_controller.sv
// Scoreboard bench for param_mem_controller: directed command streams, a cycle model of
// queue occupancy / response state, and an in-order expected read-data queue.
module tb_param_mem_controller;
    localparam int DW = 8, AW = 8, FD = 16, CW = $clog2(FD) + 1;

    logic clk_mem = 1'b0, reset = 1'b1, cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic cmd_ready, rsp_valid, full, empty;
    logic [DW-1:0] rsp_data;
    logic [CW-1:0] count;

    int checks = 0, failures = 0, rsp_seen = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mdl_mem [256];
    bit   m_q[$];
    int   m_st = 0;
    bit   m_ex_we = 1'b0;
    bit   rand_rdy = 1'b0;

    param_mem_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk_mem(clk_mem), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .full(full), .empty(empty), .count(count)
    );

    always #5 clk_mem = ~clk_mem;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference occupancy/state model: 0 idle, 1 exec, 2 resp.
    always @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_st = 0;
        end else begin
            bit p, o;
            p = cmd_valid && (m_q.size() < FD);
            o = (m_st == 0) && (m_q.size() != 0);
            case (m_st)
                0: if (o) begin m_ex_we = m_q.pop_front(); m_st = 1; end
                1: m_st = m_ex_we ? 0 : 2;
                default: if (rsp_ready) m_st = 0;
            endcase
            if (p) m_q.push_back(cmd_we);
        end
    end

    // Monitor: flags and occupancy every cycle, read data on each response handshake.
    always @(negedge clk_mem) begin
        chk("count", count, m_q.size());
        chk("rsp_valid", rsp_valid, (m_st == 2));
        chk("full", full, (m_q.size() == FD));
        chk("empty", empty, (m_q.size() == 0));
        chk("cmd_ready", cmd_ready, (m_q.size() != FD));
        if (rsp_valid && rsp_ready) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp_unexpected: got data %0h expected no response", rsp_data);
            end else begin
                chk("rsp_data", rsp_data, exp_q.pop_front());
            end
        end
    end

    always @(posedge clk_mem) if (rand_rdy) #1 rsp_ready = 1'($urandom_range(0, 1));

    task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waits);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; waits = 0;
        @(negedge clk_mem);
        while (!cmd_ready && waits < 200) begin waits++; @(negedge clk_mem); end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout: got cmd_ready=0 expected acceptance within 200 cycles");
        end else if (we) mdl_mem[a] = d;
        else exp_q.push_back(mdl_mem[a]);
        @(posedge clk_mem); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_st != 0 || m_q.size() != 0) && n < 500) begin
            @(posedge clk_mem); n++;
        end
        if (n >= 500) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
        end
        @(posedge clk_mem); #1;
    endtask

    initial begin
        int w;
        repeat (2) @(posedge clk_mem);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0); chk("rst_rsp_data", rsp_data, 0);
        chk("rst_count", count, 0); chk("rst_empty", empty, 1);
        chk("rst_full", full, 0); chk("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        rsp_ready = 1'b1;

        // Writes i -> address i, first accepted on the first edge after reset falls.
        send(1'b1, 8'd0, 8'd0, w);
        chk("first_accept_waits", w, 0);
        for (int i = 1; i < 16; i++) send(1'b1, AW'(i), DW'(i), w);
        drain();

        // Read latency: accepted at N, rsp_valid from N+2.
        rsp_seen = 0;
        send(1'b0, 8'd5, 8'd0, w);
        @(posedge clk_mem); #1;
        chk("lat_n1_valid", rsp_valid, 0);
        @(posedge clk_mem); #1;
        chk("lat_n2_valid", rsp_valid, 1);
        chk("lat_n2_data", rsp_data, 8'h05);
        drain();
        chk("lat_rsp_count", rsp_seen, 1);

        // Fill under backpressure: 17 accepted, 18th refused.
        rsp_ready = 1'b0;
        rsp_seen = 0;
        for (int k = 0; k < 17; k++) send(1'b0, AW'(k % 16), 8'd0, w);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'd7;
        repeat (3) @(negedge clk_mem);
        chk("fill_count", count, 16); chk("fill_full", full, 1);
        chk("fill_cmd_ready", cmd_ready, 0); chk("fill_rsp_valid", rsp_valid, 1);
        @(posedge clk_mem); #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        chk("fill_rsp_count", rsp_seen, 17);

        // Reset mid-operation with 5 queued and one response pending.
        rsp_ready = 1'b0;
        for (int k = 1; k <= 6; k++) send(1'b0, AW'(k), 8'd0, w);
        chk("pre_rst_count", count, 5); chk("pre_rst_valid", rsp_valid, 1);
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0); chk("mid_rst_rsp_data", rsp_data, 0);
        chk("mid_rst_count", count, 0); chk("mid_rst_empty", empty, 1);
        chk("mid_rst_full", full, 0); chk("mid_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk_mem); #1;
        reset = 1'b0;
        rsp_ready = 1'b1;
        rsp_seen = 0;
        send(1'b0, 8'd3, 8'd0, w);
        @(posedge clk_mem); @(posedge clk_mem); #1;
        chk("post_rst_data", rsp_data, 8'h03);
        drain();
        chk("post_rst_rsp_count", rsp_seen, 1);

        // 40 mixed commands across pointer wrap with random consumer stalls.
        rand_rdy = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 2) send(1'b0, AW'(32 + ((k - 1) % 8)), 8'd0, w);
            else            send(1'b1, AW'(32 + (k % 8)), DW'(k * 7 + 1), w);
        end
        rand_rdy = 1'b0;
        @(posedge clk_mem); #2;
        rsp_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion by 200000");
        $fatal(1, "watchdog");
    end
endmodule
